// File: rtl/regbank_arb_pkg.sv
// Shared types and defaults for the register-bank arbiter.
package regbank_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Master IDs; also the index into the packed req vector.
  localparam logic CORE  = 1'b0;
  localparam logic DEBUG = 1'b1;

  localparam int DATA_W_DEF   = 8;
  localparam int SEL_W_DEF    = 3;
  localparam int MAX_LOCK_DEF = 4;

endpackage

// File: rtl/regbank_rr_pick.sv
// Two-way round-robin chooser with lock continuation priority.
module regbank_rr_pick
  import regbank_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       lock_valid,
  input  logic       lock_owner,
  input  logic       lock_cnt_ok,
  output logic       grant_id,
  output logic       grant_valid
);

  logic lock_hold;

  // Lock holds while the owner still asks, unless its budget is spent and the other master waits.
  assign lock_hold = lock_valid && req[lock_owner] && (lock_cnt_ok || !req[~lock_owner]);

  // Lock first, then alternate on a tie, else whoever is asking.
  always_comb begin
    grant_valid = |req;
    if (lock_hold)     grant_id = lock_owner;
    else if (&req)     grant_id = ~rr_last;
    else               grant_id = req[DEBUG];
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Arbiter between core and debug masters for single register-bank accesses.
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SEL_W    = SEL_W_DEF,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [SEL_W-1:0]  c_rx_sel,
  input  logic [SEL_W-1:0]  c_ry_sel,
  input  logic              c_indirect,
  input  logic              c_lock,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [SEL_W-1:0]  d_rx_sel,
  input  logic [SEL_W-1:0]  d_ry_sel,
  input  logic              d_indirect,
  input  logic              d_lock,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              rb_read_en,
  output logic              rb_write_en,
  output logic [SEL_W-1:0]  rb_rx_sel,
  output logic [SEL_W-1:0]  rb_ry_sel,
  output logic              rb_indirect_en,
  output logic [DATA_W-1:0] rb_wdata,
  input  logic [DATA_W-1:0] rb_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  state_t           state, nxt;
  logic             owner, owner_lock, rr_last;
  logic [CNT_W-1:0] lock_cnt;
  logic             grant_id, grant_valid, lock_cnt_ok, lock_cont;
  logic             o_we;

  assign lock_cnt_ok = lock_cnt < CNT_W'(MAX_LOCK);
  assign o_we        = owner ? d_we : c_we;
  // Same owner with its lock latched can only come from the lock path.
  assign lock_cont   = owner_lock && (grant_id == owner);

  regbank_rr_pick u_pick (
    .req         ({d_req, c_req}),
    .rr_last     (rr_last),
    .lock_valid  (owner_lock),
    .lock_owner  (owner),
    .lock_cnt_ok (lock_cnt_ok),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Fixed IDLE -> SERVE -> DONE cycle; only IDLE waits on requests.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = grant_valid ? SERVE : IDLE;
      SERVE:   nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= CORE;
      owner_lock <= 1'b0;
      rr_last    <= DEBUG;
      lock_cnt   <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        owner      <= grant_id;
        owner_lock <= grant_id ? d_lock : c_lock;
        rr_last    <= grant_id;
        if (!lock_cont)       lock_cnt <= CNT_W'(1);
        else if (lock_cnt_ok) lock_cnt <= lock_cnt + CNT_W'(1);
      end
      if (state == SERVE && !o_we) begin
        if (owner == DEBUG) d_rdata <= rb_rdata;
        else                c_rdata <= rb_rdata;
      end
    end
  end

  // Bank strobes decode straight from state so reset kills write_en at once.
  always_comb begin
    rb_read_en     = 1'b0;
    rb_write_en    = 1'b0;
    rb_rx_sel      = '0;
    rb_ry_sel      = '0;
    rb_indirect_en = 1'b0;
    rb_wdata       = '0;
    c_ack          = 1'b0;
    d_ack          = 1'b0;
    case (state)
      SERVE: begin
        rb_write_en    = o_we;
        rb_read_en     = !o_we;
        rb_rx_sel      = owner ? d_rx_sel   : c_rx_sel;
        rb_ry_sel      = owner ? d_ry_sel   : c_ry_sel;
        rb_indirect_en = owner ? d_indirect : c_indirect;
        rb_wdata       = owner ? d_wdata    : c_wdata;
      end
      DONE: begin
        c_ack = (owner == CORE);
        d_ack = (owner == DEBUG);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with a small behavioural register bank.
module tb_regbank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c_req = 0, c_we = 0, c_indirect = 0, c_lock = 0;
  logic       d_req = 0, d_we = 0, d_indirect = 0, d_lock = 0;
  logic [2:0] c_rx_sel = 0, c_ry_sel = 0, d_rx_sel = 0, d_ry_sel = 0;
  logic [7:0] c_wdata = 0, d_wdata = 0;
  logic       c_ack, d_ack, rb_read_en, rb_write_en, rb_indirect_en;
  logic [7:0] c_rdata, d_rdata, rb_wdata, rb_rdata;
  logic [2:0] rb_rx_sel, rb_ry_sel;

  int checks = 0;
  int errors = 0;

  // Bank model; bench preloads go through the same write port.
  logic [7:0] bank [8];
  logic       pl_en = 0;
  logic [2:0] pl_addr = 0;
  logic [7:0] pl_data = 0;

  always @(posedge clk) begin
    if (rb_write_en) bank[rb_rx_sel] <= rb_wdata;
    else if (pl_en)  bank[pl_addr]   <= pl_data;
  end

  assign rb_rdata = !rb_read_en ? 8'h00 :
                    rb_indirect_en ? bank[bank[rb_ry_sel][2:0]] : bank[rb_ry_sel];

  always #5 clk = ~clk;

  regbank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_rx_sel(c_rx_sel), .c_ry_sel(c_ry_sel),
    .c_indirect(c_indirect), .c_lock(c_lock), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_rx_sel(d_rx_sel), .d_ry_sel(d_ry_sel),
    .d_indirect(d_indirect), .d_lock(d_lock), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .rb_read_en(rb_read_en), .rb_write_en(rb_write_en),
    .rb_rx_sel(rb_rx_sel), .rb_ry_sel(rb_ry_sel),
    .rb_indirect_en(rb_indirect_en), .rb_wdata(rb_wdata), .rb_rdata(rb_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] v);
    pl_en = 1; pl_addr = a; pl_data = v;
    step();
    pl_en = 0;
  endtask

  // Step until an ack appears (bounded); report who and how many edges it took.
  task automatic wait_ack(input string tag, output logic is_d, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(c_ack || d_ack) && n < 12);
    chk({tag, "_ack_seen"}, {31'd0, c_ack || d_ack}, 32'd1);
    chk({tag, "_ack_excl"}, {31'd0, c_ack && d_ack}, 32'd0);
    is_d = d_ack;
  endtask

  logic is_d;
  int   n;
  logic exp_lock [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state
    #2;
    chk("rst_we",    {31'd0, rb_write_en}, 0);
    chk("rst_re",    {31'd0, rb_read_en}, 0);
    chk("rst_acks",  {30'd0, c_ack, d_ack}, 0);
    chk("rst_rdata", {16'd0, c_rdata, d_rdata}, 0);
    step();
    rst_n = 1;
    preload(3'd1, 8'h11);
    preload(3'd2, 8'h22);
    preload(3'd3, 8'h00);
    preload(3'd4, 8'h06);
    preload(3'd5, 8'h00);
    preload(3'd6, 8'h77);

    // Core write r3=0x5A, then read it back
    c_req = 1; c_we = 1; c_rx_sel = 3; c_wdata = 8'h5A;
    step();
    chk("wr_serve_we",   {31'd0, rb_write_en}, 1);
    chk("wr_serve_re",   {31'd0, rb_read_en}, 0);
    chk("wr_serve_rx",   {29'd0, rb_rx_sel}, 3);
    chk("wr_serve_data", {24'd0, rb_wdata}, 32'h5A);
    step();
    chk("wr_done_ack",   {30'd0, c_ack, d_ack}, 2'b10);
    chk("wr_done_we",    {31'd0, rb_write_en}, 0);
    chk("wr_bank",       {24'd0, bank[3]}, 32'h5A);
    chk("wr_rdata_hold", {24'd0, c_rdata}, 0);
    c_we = 0; c_ry_sel = 3;
    step();
    chk("rd_idle_ack", {30'd0, c_ack, d_ack}, 0);
    step();
    chk("rd_serve_re", {31'd0, rb_read_en}, 1);
    chk("rd_serve_we", {31'd0, rb_write_en}, 0);
    step();
    chk("rd_ack",   {30'd0, c_ack, d_ack}, 2'b10);
    chk("rd_rdata", {24'd0, c_rdata}, 32'h5A);
    c_req = 0;
    step();
    step();
    chk("idle_no_req", {31'd0, rb_read_en | rb_write_en}, 0);

    // Simultaneous requests alternate; core was last so debug goes first
    c_req = 1; c_ry_sel = 1;
    d_req = 1; d_we = 0; d_ry_sel = 2;
    for (int i = 0; i < 4; i++) begin
      wait_ack("rr", is_d, n);
      chk("rr_order", {31'd0, is_d}, (i % 2 == 0) ? 1 : 0);
      if (i > 0) chk("rr_gap", n, 3);
    end
    chk("rr_c_rdata", {24'd0, c_rdata}, 32'h11);
    chk("rr_d_rdata", {24'd0, d_rdata}, 32'h22);
    c_req = 0; d_req = 0;
    step();

    // Indirect read: r4=6, r6=0x77
    d_req = 1; d_ry_sel = 4; d_indirect = 1;
    step();
    chk("ind_en", {31'd0, rb_indirect_en}, 1);
    wait_ack("ind", is_d, n);
    chk("ind_who",   {31'd0, is_d}, 1);
    chk("ind_rdata", {24'd0, d_rdata}, 32'h77);
    d_req = 0; d_indirect = 0;
    step();

    // Debug lock for 6 accesses with core waiting: 4 debug, core, debug resumes
    d_req = 1; d_ry_sel = 2; d_lock = 1;
    step();
    c_req = 1; c_ry_sel = 1;
    for (int i = 0; i < 7; i++) begin
      wait_ack("lock", is_d, n);
      chk("lock_order", {31'd0, is_d}, {31'd0, exp_lock[i]});
    end
    c_req = 0; d_req = 0;
    step();

    // Locked debug drops req while core waits: core granted without idle hold
    d_req = 1; d_lock = 1;
    step();
    c_req = 1;
    wait_ack("drop1", is_d, n);
    chk("drop_first", {31'd0, is_d}, 1);
    d_req = 0; d_lock = 0;
    wait_ack("drop2", is_d, n);
    chk("drop_core", {31'd0, is_d}, 0);
    chk("drop_gap",  n, 3);
    c_req = 0;
    step();

    // Reset during a SERVE write of 0xFF to r5
    c_req = 1; c_we = 1; c_rx_sel = 5; c_wdata = 8'hFF;
    step();
    chk("rstw_serve_we", {31'd0, rb_write_en}, 1);
    #1 rst_n = 0;
    #1;
    chk("rstw_we_drop", {31'd0, rb_write_en}, 0);
    c_req = 0; c_we = 0;
    step();
    chk("rstw_no_ack", {30'd0, c_ack, d_ack}, 0);
    chk("rstw_bank",   {24'd0, bank[5]}, 0);
    rst_n = 1;
    c_req = 1; c_ry_sel = 1; d_req = 1; d_ry_sel = 2;
    wait_ack("rstw_tie", is_d, n);
    chk("rstw_core_first", {31'd0, is_d}, 0);
    chk("rstw_core_rdata", {24'd0, c_rdata}, 32'h11);
    c_req = 0; d_req = 0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

endmodule
